sd_cmd_resp_rx: RTL

//  Receives SD/SDIO card responses on the CMD line. It is the downstream partner of the command transmitter.
//  The transmitter arms it after driving the end bit and releasing CMD.
//  The block samples CMD on the host's SD-clock rising-edge strobe, hunts for the start bit,

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_crc7.sv | 21 ++
 rtl/sd_cmd_resp_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD types, frame lengths and CRC7 polynomial
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        DONE
    } state_t;

    localparam int SD_RESP_SHORT_LEN = 48;
    localparam int SD_RESP_LONG_LEN  = 136;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    // One serial step of the x^7+x^3+1 LFSR, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 LFSR shared by the CMD-line transmitter and receiver
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// rtl/sd_cmd_resp_rx.sv - SD CMD-line response receiver (48/136-bit); CRC7 check under SD_RESP_CRC_CHECK_EN
module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 64,
    parameter int TO_W    = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic         cmd_in,
    input  logic         arm,
    input  logic         long_resp,
    output logic         busy,
    output logic         resp_valid,
    output logic [5:0]   resp_index,
    output logic [127:0] resp_data,
    output logic         crc_err,
    output logic         frame_err,
    output logic         timeout
);

    state_t           state;
    logic             long_q;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       bit_cnt;
    logic [134:0]     sreg;
    logic [135:0]     sreg_nxt;
    logic [7:0]       frame_len;
    logic             last_bit;
    logic [5:0]       idx_f;
    logic [127:0]     data_f;
    logic             ferr_f;
    logic             crc_bad;

    always_comb begin
        sreg_nxt  = {sreg, cmd_in};
        frame_len = long_q ? 8'(SD_RESP_LONG_LEN) : 8'(SD_RESP_SHORT_LEN);
        last_bit  = (bit_cnt == frame_len - 8'd1);
        if (long_q) begin
            idx_f  = sreg_nxt[133:128];
            data_f = {sreg_nxt[127:1], 1'b0};
            ferr_f = sreg_nxt[135] | sreg_nxt[134] | ~sreg_nxt[0];
        end else begin
            idx_f  = sreg_nxt[45:40];
            data_f = {96'b0, sreg_nxt[39:8]};
            ferr_f = sreg_nxt[47] | sreg_nxt[46] | ~sreg_nxt[0];
        end
    end

`ifdef SD_RESP_CRC_CHECK_EN
    logic       crc_feed;
    logic       crc_clr;
    logic [6:0] crc;

    // Short frames cover start..argument; R2 skips its first 8 bits (start, tx, 6'h3F).
    always_comb begin
        crc_clr  = (state == IDLE) && arm;
        crc_feed = 1'b0;
        if (sample_en) begin
            if (state == WAIT_START) begin
                crc_feed = !cmd_in && !long_q;
            end else if (state == SHIFT) begin
                if (long_q) begin
                    crc_feed = (bit_cnt >= 8'd8) && (bit_cnt <= 8'(SD_RESP_LONG_LEN - 9));
                end else begin
                    crc_feed = (bit_cnt <= 8'(SD_RESP_SHORT_LEN - 9));
                end
            end
        end
    end

    sd_crc7 u_crc7 (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_feed),
        .din (cmd_in),
        .crc (crc)
    );

    assign crc_bad = (crc != sreg_nxt[7:1]);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            long_q     <= 1'b0;
            to_cnt     <= '0;
            bit_cnt    <= 8'd0;
            sreg       <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_index <= 6'd0;
            resp_data  <= 128'd0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= WAIT_START;
                        long_q  <= long_resp;
                        to_cnt  <= '0;
                        bit_cnt <= 8'd0;
                        sreg    <= '0;
                        busy    <= 1'b1;
                    end
                end
                WAIT_START: begin
                    if (sample_en) begin
                        if (!cmd_in) begin
                            sreg    <= sreg_nxt[134:0];
                            bit_cnt <= 8'd1;
                            state   <= SHIFT;
                        end else if (to_cnt == TO_W'(NCR_MAX - 1)) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (sample_en) begin
                        sreg    <= sreg_nxt[134:0];
                        bit_cnt <= bit_cnt + 8'd1;
                        // Fields are registered off the end-bit sample so they appear one clk later.
                        if (last_bit) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_index <= idx_f;
                            resp_data  <= data_f;
                            crc_err    <= crc_bad;
                            frame_err  <= ferr_f;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
